// File: rtl/morph_pkg.sv
// Shared definitions for the streaming binary morphology filter:
// mode encoding, FSM states and the per-mode neutral pad value.
package morph_pkg;

  localparam logic MODE_ERODE  = 1'b0;
  localparam logic MODE_DILATE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Neutral element of the window reduction: 1 for AND (erode), 0 for OR (dilate)
  function automatic logic pad_value(input logic mode);
    return (mode == MODE_ERODE);
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// Cascade of LINES shift-register line delays of DEPTH bits each.
// o_taps[0] is the incoming pixel, o_taps[j] the pixel j lines earlier.
module morph_line_buffer
  import morph_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int LINES = 2
) (
  input  logic           clk,
  input  logic           i_shift,
  input  logic           i_pixel,
  output logic [LINES:0] o_taps
);

  logic [DEPTH-1:0] r_line [LINES];

  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_line[0] <= {r_line[0][DEPTH-2:0], i_pixel};
      for (int j = 1; j < LINES; j++) begin
        r_line[j] <= {r_line[j][DEPTH-2:0], r_line[j-1][DEPTH-1]};
      end
    end
  end

  always_comb begin
    o_taps[0] = i_pixel;
    for (int j = 0; j < LINES; j++) begin
      o_taps[j+1] = r_line[j][DEPTH-1];
    end
  end

endmodule

// File: rtl/morph_filter_kxk.sv
// KxK binary erosion/dilation on a raster pixel stream with neutral border
// padding, per-frame mode, end-of-frame flush and early-restart detection.
module morph_filter_kxk
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int K          = 3,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mode,
  input  logic i_pixel,
  input  logic i_valid,
  input  logic i_sof,
  output logic o_ready,
  output logic o_pixel,
  output logic o_valid,
  output logic o_sof,
  output logic o_eof,
  output logic o_frame_err
);

  localparam int R  = (K - 1) / 2;
  // Flush positions run R rows past the frame, so the row counter needs one extra bit
  localparam int RW = ROW_W + 1;

  generate
    if (K < 3 || K > 7 || (K % 2) == 0 || IMG_WIDTH < K || IMG_HEIGHT < K) begin : g_bad_param
      $error("morph_filter_kxk: K must be odd in 3..7 and not exceed the image size");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic             r_mode, w_mode;
  logic [COL_W-1:0] r_in_col, w_pos_col;
  logic [RW-1:0]    r_in_row, w_pos_row;
  logic             w_acc, w_sof_acc, w_adv, w_restart, w_pix_in;
  logic [K-1:0]     w_taps;
  logic [K-1:0]     r_win [K];
  logic [K-1:0]     w_win_nxt [K];
  int               w_ctr_col, w_ctr_row;
  logic             w_ctr_in, w_ctr_first, w_ctr_last;
  logic             w_tap, w_and, w_or, w_red;
  logic             r_pix_p1, r_vld_p1, r_sof_p1, r_eof_p1, r_err_p1;

  assign o_ready   = (r_state != FLUSH);
  assign w_acc     = i_valid & o_ready;
  assign w_sof_acc = w_acc & i_sof;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // w_pos_* is the raster position of the pixel entering the window this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_restart   = 1'b0;
    w_pix_in    = pad_value(r_mode);
    w_mode      = r_mode;
    w_pos_col   = r_in_col;
    w_pos_row   = r_in_row;
    case (r_state)
      IDLE: begin
        if (w_sof_acc) begin
          w_adv       = 1'b1;
          w_pix_in    = i_pixel;
          w_mode      = i_mode;
          w_pos_col   = '0;
          w_pos_row   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_acc) begin
          w_adv    = 1'b1;
          w_pix_in = i_pixel;
          if (i_sof) begin
            w_restart = 1'b1;
            w_mode    = i_mode;
            w_pos_col = '0;
            w_pos_row = '0;
          end else if (r_in_row == RW'(IMG_HEIGHT - 1) && r_in_col == COL_W'(IMG_WIDTH - 1)) begin
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        w_adv = 1'b1;
        // This pad position centres the window on the last frame pixel
        if (r_in_row == RW'(IMG_HEIGHT + R) && r_in_col == COL_W'(R - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_col <= '0;
      r_in_row <= '0;
      r_mode   <= MODE_ERODE;
    end else if (w_adv) begin
      r_mode <= w_mode;
      if (w_pos_col == COL_W'(IMG_WIDTH - 1)) begin
        r_in_col <= '0;
        r_in_row <= w_pos_row + 1'b1;
      end else begin
        r_in_col <= w_pos_col + 1'b1;
        r_in_row <= w_pos_row;
      end
    end
  end

  always_comb begin
    if (int'(w_pos_col) >= R) begin
      w_ctr_col = int'(w_pos_col) - R;
      w_ctr_row = int'(w_pos_row) - R;
    end else begin
      w_ctr_col = int'(w_pos_col) + IMG_WIDTH - R;
      w_ctr_row = int'(w_pos_row) - R - 1;
    end
    w_ctr_in    = (w_ctr_row >= 0) && (w_ctr_row < IMG_HEIGHT);
    w_ctr_first = (w_ctr_row == 0) && (w_ctr_col == 0);
    w_ctr_last  = (w_ctr_row == IMG_HEIGHT - 1) && (w_ctr_col == IMG_WIDTH - 1);
  end

  morph_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .LINES (K - 1)
  ) u_line_buffer (
    .clk     (clk),
    .i_shift (w_adv),
    .i_pixel (w_pix_in),
    .o_taps  (w_taps)
  );

  // Stage p0: shifted window; out-of-frame taps (incl. line wrap) become neutral
  always_comb begin
    w_tap = 1'b0;
    w_and = 1'b1;
    w_or  = 1'b0;
    for (int r = 0; r < K; r++) begin
      w_win_nxt[r] = {w_taps[K-1-r], r_win[r][K-1:1]};
      for (int c = 0; c < K; c++) begin
        if ((w_ctr_row + r - R >= 0) && (w_ctr_row + r - R < IMG_HEIGHT) &&
            (w_ctr_col + c - R >= 0) && (w_ctr_col + c - R < IMG_WIDTH)) begin
          w_tap = w_win_nxt[r][c];
        end else begin
          w_tap = pad_value(w_mode);
        end
        w_and = w_and & w_tap;
        w_or  = w_or | w_tap;
      end
    end
    w_red = (w_mode == MODE_DILATE) ? w_or : w_and;
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int r = 0; r < K; r++) begin
        r_win[r] <= w_win_nxt[r];
      end
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_p1 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_sof_p1 <= 1'b0;
      r_eof_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_adv & w_ctr_in;
      r_sof_p1 <= w_adv & w_ctr_first;
      r_eof_p1 <= w_adv & w_ctr_last;
      r_err_p1 <= w_restart;
      if (w_adv & w_ctr_in) r_pix_p1 <= w_red;
    end
  end

  assign o_pixel     = r_pix_p1;
  assign o_valid     = r_vld_p1;
  assign o_sof       = r_sof_p1;
  assign o_eof       = r_eof_p1;
  assign o_frame_err = r_err_p1;

endmodule
